// File: rtl/ins_fetch.sv
// Instruction fetch: streams words from imem to decode, with a one-entry skid buffer.
// Latency: a word acked in cycle N reaches insDecode_* after edge N+1.
// Backpressure: stall holds the outputs; one acked word is parked in the skid buffer and requests pause.
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insDecode_pc,
  output logic [31:0] insDecode_ins,
  output logic        insDecode_valid
);

  typedef enum logic {
    FETCH    = 1'b0,
    BUFFERED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic        out_vld_q, out_vld_d;

  // The address always tracks pc, so it is naturally stable while a request waits for ack.
  assign imem_addr       = pc_q;
  // No request while the skid buffer is full or the block is held in reset.
  assign imem_req        = (state_q == FETCH) && !rst;
  assign insDecode_pc    = out_pc_q;
  assign insDecode_ins   = out_ins_q;
  assign insDecode_valid = out_vld_q;

  // Next-state logic: redirect first, then the FETCH/BUFFERED handshake cases.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;
    out_pc_d  = out_pc_q;
    out_ins_d = out_ins_q;
    out_vld_d = out_vld_q;

    if (redirect) begin
      // Flush everything in flight, including a word acked this very cycle.
      pc_d      = {redirect_pc[31:2], 2'b00};
      out_pc_d  = 32'h0;
      out_ins_d = 32'h0;
      out_vld_d = 1'b0;
      buf_pc_d  = 32'h0;
      buf_ins_d = 32'h0;
      state_d   = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack && !stall) begin
            out_pc_d  = pc_q;
            out_ins_d = imem_rdata;
            out_vld_d = 1'b1;
            pc_d      = pc_q + 32'd4;
          end else if (imem_ack && stall) begin
            // Decode is busy: park the word and stop requesting until it drains.
            buf_pc_d  = pc_q;
            buf_ins_d = imem_rdata;
            pc_d      = pc_q + 32'd4;
            state_d   = BUFFERED;
          end else if (!imem_ack && !stall) begin
            // Memory wait state: present an explicit NOP bubble.
            out_pc_d  = 32'h0;
            out_ins_d = 32'h0;
            out_vld_d = 1'b0;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            out_pc_d  = buf_pc_q;
            out_ins_d = buf_ins_q;
            out_vld_d = 1'b1;
            state_d   = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      buf_pc_q  <= 32'h0;
      buf_ins_q <= 32'h0;
      out_pc_q  <= 32'h0;
      out_ins_q <= 32'h0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
      out_pc_q  <= out_pc_d;
      out_ins_q <= out_ins_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: streaming, wait states, stall, redirect, wrap, reset.
// Memory returns addr ^ 32'hA5A5_0000 whenever the bench raises ack.
// Outputs are sampled 1 time unit after each rising edge.
module tb_ins_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] insDecode_pc;
  logic [31:0] insDecode_ins;
  logic        insDecode_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  ins_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .insDecode_pc    (insDecode_pc),
    .insDecode_ins   (insDecode_ins),
    .insDecode_valid (insDecode_valid)
  );

  assign imem_rdata = imem_addr ^ PAT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic vld);
    check_eq({tag, "_pc"}, insDecode_pc, pc);
    check_eq({tag, "_ins"}, insDecode_ins, ins);
    check_eq({tag, "_vld"}, {31'b0, insDecode_valid}, {31'b0, vld});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    tick();
    tick();
    // Reset state
    check_out("rst", 32'h0, 32'h0, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_req", {31'b0, imem_req}, 32'h1);

    // Streaming, zero wait states: pc 0,4,8,12
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stream", 32'(4 * i), 32'(4 * i) ^ PAT, 1'b1);
    end
    check_eq("stream_addr", imem_addr, 32'd16);

    // Wait states: ack every third cycle -> two bubbles, then 16, then 20
    for (int r = 0; r < 2; r++) begin
      imem_ack = 1'b0;
      tick();
      check_out("ws_bub1", 32'h0, 32'h0, 1'b0);
      check_eq("ws_addr_hold", imem_addr, 32'(16 + 4 * r));
      tick();
      check_out("ws_bub2", 32'h0, 32'h0, 1'b0);
      imem_ack = 1'b1;
      tick();
      check_out("ws_ins", 32'(16 + 4 * r), 32'(16 + 4 * r) ^ PAT, 1'b1);
    end

    // Stall on ack of pc 24 for 3 cycles: outputs hold 20, req low in BUFFERED
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold", 32'd20, 32'd20 ^ PAT, 1'b1);
      check_eq("stall_req", {31'b0, imem_req}, 32'h0);
      check_eq("stall_addr", imem_addr, 32'd28);
    end
    stall = 1'b0;
    tick();
    check_out("unstall_buf", 32'd24, 32'd24 ^ PAT, 1'b1);
    check_eq("unstall_req", {31'b0, imem_req}, 32'h1);
    tick();
    check_out("unstall_next", 32'd28, 32'd28 ^ PAT, 1'b1);

    // Redirect while BUFFERED with stall high: buffer (pc 32) is lost
    stall = 1'b1;
    tick();
    check_eq("pre_redir_req", {31'b0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    check_out("redir", 32'h0, 32'h0, 1'b0);
    check_eq("redir_addr", imem_addr, 32'h0000_0100);
    check_eq("redir_req", {31'b0, imem_req}, 32'h1);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check_out("redir_first", 32'h0000_0100, 32'h0000_0100 ^ PAT, 1'b1);

    // Wrap: redirect to last word (data acked that cycle is dropped)
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    check_out("wrap_redir", 32'h0, 32'h0, 1'b0);
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check_out("wrap_top", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);
    check_eq("wrap_addr1", imem_addr, 32'h0);
    tick();
    check_out("wrap_zero", 32'h0, PAT, 1'b1);

    // Reset in BUFFERED: buffer (pc 4) and outputs cleared
    stall = 1'b1;
    tick();
    check_eq("pre_rst_req", {31'b0, imem_req}, 32'h0);
    check_out("pre_rst_hold", 32'h0, PAT, 1'b1);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    check_out("mid_rst", 32'h0, 32'h0, 1'b0);
    check_eq("mid_rst_addr", imem_addr, 32'h0);
    check_eq("mid_rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    #1;
    check_eq("post_rst_req", {31'b0, imem_req}, 32'h1);
    tick();
    check_out("post_rst_first", 32'h0, PAT, 1'b1);
    tick();
    check_out("post_rst_second", 32'd4, 32'd4 ^ PAT, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  decode cannot accept a new instruction this cycle.
REQ-005 SHALL have port redirect  input  1  flush and restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  32  byte address of the requested word.
REQ-009 SHALL have port imem_ack  input  1  imem_rdata valid for the current imem_addr this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port insDecode_pc  output  32  registered PC of the instruction presented to decode.
REQ-012 SHALL have port insDecode_ins  output  32  registered instruction presented to decode.
REQ-013 SHALL have port insDecode_valid  output  1  insDecode_pc/insDecode_ins hold a real instruction.

Function
REQ-014 SHALL hold an internal 32-bit pc, a one-entry skid buffer {buf_pc, buf_ins}, and a two-state FSM: FETCH, BUFFERED.
REQ-015 SHALL drive imem_addr = pc at all times, and imem_req = 1 in FETCH and 0 in BUFFERED or while rst = 1.
REQ-016 SHALL keep imem_addr stable while imem_req = 1 and imem_ack = 0, unless redirect = 1.
REQ-017 FETCH, imem_ack = 1, stall = 0: SHALL load outputs with {pc, imem_rdata}, set valid = 1, set pc = pc + 4, and stay in FETCH (one instruction per cycle at zero wait states).
REQ-018 FETCH, imem_ack = 1, stall = 1: SHALL hold the outputs, capture {pc, imem_rdata} into the skid buffer, set pc = pc + 4, and move to BUFFERED.
REQ-019 FETCH, imem_ack = 0, stall = 0: SHALL insert a bubble: valid = 0, insDecode_ins = 0 (NOP), insDecode_pc = 0.
REQ-020 FETCH, imem_ack = 0, stall = 1: SHALL hold all outputs and pc.
REQ-021 BUFFERED, stall = 1: SHALL hold the outputs and the buffer.
REQ-022 BUFFERED, stall = 0: SHALL move the buffer into the outputs with valid = 1, and return to FETCH.
REQ-023 redirect = 1 SHALL take priority over stall and ack, and SHALL cause the following on the next edge:
- pc = {redirect_pc[31:2], 2'b00};
- outputs cleared to pc = 0, ins = 0, valid = 0;
- skid buffer discarded;
- state = FETCH;
- any imem_rdata acked in the same cycle dropped.
REQ-024 pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-025 SHALL never drop, duplicate or reorder instructions absent redirect; the insDecode_pc sequence of valid outputs increases strictly by 4.
REQ-026 Latency: an instruction acked in cycle N with stall = 0 SHALL appear on the outputs after edge N+1.

Reset
REQ-027 With rst = 1 at an edge, the block SHALL set:
- pc = RESET_PC;
- state = FETCH;
- skid buffer cleared;
- insDecode_pc = 0, insDecode_ins = 0, insDecode_valid = 0.
REQ-028 rst SHALL override redirect, stall and ack, including mid-request and in BUFFERED; imem_req rises in the first cycle with rst = 0.

Verification
REQ-029 Streaming, RESET_PC = 0, ack held 1, stall 0, rdata = addr ^ 32'hA5A5_0000 -> valid outputs pc 0, 4, 8, ... one per cycle with matching ins.
REQ-030 Wait states: ack on every third cycle -> outputs show two bubbles (valid = 0, ins = 0) between instructions, with no skipped PC.
REQ-031 Stall on ack: stall = 1 for 3 cycles while the ack for pc 8 arrives -> outputs hold pc 4; req = 0 in BUFFERED; after release, pc 8 appears, then pc 12.
REQ-032 Redirect: redirect_pc = 32'h0000_0103 while in BUFFERED with stall = 1 -> next cycle valid = 0, buffer lost, imem_addr = 32'h0000_0100.
REQ-033 Wrap: redirect to 32'hFFFF_FFFC -> next imem_addr is 0.
REQ-034 Reset mid-operation: rst = 1 for one cycle in BUFFERED -> outputs 0, valid 0, imem_addr = RESET_PC, req = 1 in the following cycle.
